// File: rtl/joy_step_conditioner.sv
// Joystick conditioning: synchronise and debounce four direction pins, arbitrate one direction,
// emit typematic step pulses and keep a clamped cursor with a vsync-latched copy.
module joy_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_RATE     = 2500000,
    parameter int X_INIT          = 320,
    parameter int Y_INIT          = 240,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       vsync,
    output logic       step_valid,
    output logic [1:0] step_dir,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [9:0] player_x,
    output logic [9:0] player_y
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    level;
    logic [CW-1:0] cnt [4];
    logic          dir_active;
    logic [1:0]    dir;
    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [1:0]    last_dir;
    logic [1:0]    last_dir_next;
    logic          pulse;
    logic          vsync_d;

    // Bit order matches the step_dir encoding, so the lowest set bit is the priority winner.
    assign raw = {down, up, right, left};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        dir_active = |level;
        dir        = 2'd0;
        if (level[0])      dir = 2'd0;
        else if (level[1]) dir = 2'd1;
        else if (level[2]) dir = 2'd2;
        else if (level[3]) dir = 2'd3;
    end

    always_comb begin
        state_next    = state;
        timer_next    = timer;
        last_dir_next = last_dir;
        pulse         = 1'b0;
        case (state)
            IDLE: begin
                if (dir_active) begin
                    pulse         = 1'b1;
                    timer_next    = TW'(REPEAT_DELAY - 1);
                    last_dir_next = dir;
                    state_next    = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!dir_active) begin
                    state_next = IDLE;
                end else if (dir != last_dir) begin
                    pulse         = 1'b1;
                    timer_next    = TW'(REPEAT_DELAY - 1);
                    last_dir_next = dir;
                    state_next    = DELAY;
                end else if (timer == '0) begin
                    pulse      = 1'b1;
                    timer_next = TW'(REPEAT_RATE - 1);
                    state_next = REPEAT;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            last_dir   <= 2'd0;
            step_valid <= 1'b0;
            step_dir   <= 2'd0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            last_dir   <= last_dir_next;
            step_valid <= pulse;
            if (pulse) step_dir <= dir;
        end
    end

    // Saturating cursor; a clamped step still strobes but leaves the position alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            joy_x <= 10'(X_INIT);
            joy_y <= 10'(Y_INIT);
        end else if (step_valid) begin
            case (step_dir)
                2'd0: if (joy_x != 10'd0)       joy_x <= joy_x - 1'b1;
                2'd1: if (joy_x != 10'(X_MAX))  joy_x <= joy_x + 1'b1;
                2'd2: if (joy_y != 10'd0)       joy_y <= joy_y - 1'b1;
                default: if (joy_y != 10'(Y_MAX)) joy_y <= joy_y + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_d  <= 1'b0;
            player_x <= 10'(X_INIT);
            player_y <= 10'(Y_INIT);
        end else begin
            vsync_d <= vsync;
            if (vsync && !vsync_d) begin
                player_x <= joy_x;
                player_y <= joy_y;
            end
        end
    end

endmodule

// File: tb/tb_joy_step_conditioner.sv
// Randomised and directed bench for joy_step_conditioner against a schedule-based reference model.
module tb_joy_step_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic       clk;
    logic       reset;
    logic       left, right, up, down;
    logic       vsync;
    logic       step_valid;
    logic [1:0] step_dir;
    logic [9:0] joy_x, joy_y, player_x, player_y;

    int total_count = 0;
    int bad_count   = 0;

    // Reference model state
    bit [3:0] raw_q[$];
    bit [3:0] m_deb;
    bit       m_active;
    int       m_cur, m_next, m_t;
    bit       m_pulse;
    int       m_pdir;
    int       m_x, m_y, m_px, m_py;
    bit       m_vs_prev;

    joy_step_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .left(left),
        .right(right),
        .up(up),
        .down(down),
        .vsync(vsync),
        .step_valid(step_valid),
        .step_dir(step_dir),
        .joy_x(joy_x),
        .joy_y(joy_y),
        .player_x(player_x),
        .player_y(player_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total_count++;
        if (observed != expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        for (int i = 0; i < DB + 2; i++) raw_q.push_back(4'b0);
        m_deb = '0; m_active = 0; m_cur = 0; m_next = 0; m_t = 0;
        m_pulse = 0; m_pdir = 0;
        m_x = 320; m_y = 240; m_px = 320; m_py = 240;
        m_vs_prev = 0;
    endtask

    // A pin level is accepted once the synchronised pin (two samples late) has
    // disagreed with the accepted level for DB consecutive samples.
    task automatic model_step(input bit [3:0] p, input bit v);
        bit [3:0] old_deb = m_deb;
        bit       old_pulse = m_pulse;
        int       old_pdir = m_pdir;
        int       old_x = m_x;
        int       old_y = m_y;
        int       win;
        int       n;
        bit       all_diff;

        m_pulse = 0;
        if (old_deb == 4'b0) begin
            m_active = 0;
        end else begin
            win = 0;
            while (!old_deb[win]) win++;
            if (!m_active || win != m_cur) begin
                m_pulse = 1; m_pdir = win; m_cur = win; m_active = 1; m_next = m_t + RD;
            end else if (m_t == m_next) begin
                m_pulse = 1; m_pdir = win; m_next = m_t + RR;
            end
        end

        if (old_pulse) begin
            case (old_pdir)
                0: if (m_x > 0)   m_x--;
                1: if (m_x < 639) m_x++;
                2: if (m_y > 0)   m_y--;
                default: if (m_y < 479) m_y++;
            endcase
        end

        if (v && !m_vs_prev) begin
            m_px = old_x;
            m_py = old_y;
        end
        m_vs_prev = v;

        n = raw_q.size();
        for (int i = 0; i < 4; i++) begin
            all_diff = 1;
            for (int k = n - 1 - DB; k <= n - 2; k++)
                if (raw_q[k][i] == old_deb[i]) all_diff = 0;
            if (all_diff) m_deb[i] = ~old_deb[i];
        end
        raw_q.push_back(p);
        if (raw_q.size() > DB + 2) void'(raw_q.pop_front());
        m_t++;
    endtask

    task automatic check_all();
        checkOutput("step_valid", step_valid, m_pulse);
        if (m_pulse) checkOutput("step_dir", step_dir, m_pdir);
        checkOutput("joy_x", joy_x, m_x);
        checkOutput("joy_y", joy_y, m_y);
        checkOutput("player_x", player_x, m_px);
        checkOutput("player_y", player_y, m_py);
    endtask

    // One clock: drive at the falling edge, compare 1 time unit after the rising edge.
    task automatic applyStimulus(input bit [3:0] p, input bit v);
        @(negedge clk);
        {down, up, right, left} = p;
        vsync = v;
        @(posedge clk);
        #1;
        model_step(p, v);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_step_valid", step_valid, 0);
        checkOutput("rst_joy_x", joy_x, 320);
        checkOutput("rst_joy_y", joy_y, 240);
        checkOutput("rst_player_x", player_x, 320);
        checkOutput("rst_player_y", player_y, 240);
        @(negedge clk);
        {down, up, right, left} = 4'b0;
        vsync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_step(4'b0, 1'b0);
        check_all();
    endtask

    initial begin
        int pulses[$];
        int bounce_steps;
        int guard;
        bit [3:0] p;
        int len;

        reset = 1'b0;
        {down, up, right, left} = 4'b0;
        vsync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_step_valid", step_valid, 0);
        checkOutput("init_joy_x", joy_x, 320);
        checkOutput("init_player_y", player_y, 240);
        do_reset();
        repeat (4) applyStimulus(4'b0, 1'b0);

        // Bounce shorter than the debounce window
        bounce_steps = 0;
        for (int r = 0; r < 5; r++) begin
            repeat (3) begin applyStimulus(4'b0010, 1'b0); bounce_steps += step_valid; end
            repeat (3) begin applyStimulus(4'b0000, 1'b0); bounce_steps += step_valid; end
        end
        repeat (6) begin applyStimulus(4'b0000, 1'b0); bounce_steps += step_valid; end
        checkOutput("bounce_steps", bounce_steps, 0);
        checkOutput("bounce_joy_x", joy_x, 320);

        // Hold right for 30 cycles with vsync rising on step cycles
        for (int c = 0; c < 30; c++) begin
            applyStimulus(4'b0010, m_pulse);
            if (step_valid) pulses.push_back(c);
        end
        while (pulses.size() < 4) pulses.push_back(-1);
        checkOutput("first_pulse_lat", pulses[0], 6);
        checkOutput("repeat1_gap", pulses[1] - pulses[0], 10);
        checkOutput("repeat2_gap", pulses[2] - pulses[0], 13);
        checkOutput("repeat3_gap", pulses[3] - pulses[0], 16);
        repeat (12) applyStimulus(4'b0000, 1'b0);

        // Priority: left wins over up, then release left
        repeat (20) applyStimulus(4'b0101, 1'b0);
        repeat (20) applyStimulus(4'b0100, 1'b0);
        repeat (10) applyStimulus(4'b0000, 1'b1);

        // Reset mid-repeat while a step strobe is high
        guard = 0;
        do begin
            applyStimulus(4'b0010, 1'b0);
            guard++;
        end while (!(m_pulse && m_t > 20) && guard < 60);
        checkOutput("pre_reset_pulse", step_valid, 1);
        do_reset();
        repeat (10) applyStimulus(4'b0000, 1'b0);

        // Clamp at the lower x bound and the upper y bound
        repeat (1100) applyStimulus(4'b0001, ($urandom_range(0, 7) == 0));
        checkOutput("clamp_joy_x", joy_x, 0);
        repeat (10) applyStimulus(4'b0000, 1'b0);
        repeat (850) applyStimulus(4'b1000, ($urandom_range(0, 7) == 0));
        checkOutput("clamp_joy_y", joy_y, 479);
        repeat (10) applyStimulus(4'b0000, 1'b0);

        // Random direction mixes and frame syncs
        for (int s = 0; s < 80; s++) begin
            p   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 25);
            repeat (len) applyStimulus(p, ($urandom_range(0, 5) == 0));
        end
        repeat (12) applyStimulus(4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
